// File: rtl/alu_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_param
// Purpose  : Two-stage pipelined, width-parametrised ALU with valid/ready
//            handshakes on both sides, illegal-opcode detection and sticky
//            status-flag accumulation.
// Ports    : clk, rst             clock, asynchronous active-high reset
//            inValid/inReady      operand beat handshake
//            opcode, input1,
//            input2, shiftValue   operation select and operands
//            outValid/outReady    result beat handshake
//            result, carryFlag,
//            zeroFlag,
//            overFlowFlag,
//            signFlag, illegalOp  registered result and per-beat flags
//            clearSticky          clears the accumulated flags
//            stickyFlags          {carry,zero,overflow,sign} OR-accumulated
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             overFlowFlag,
    output logic             signFlag,
    output logic             illegalOp,
    input  logic             clearSticky,
    output logic [3:0]       stickyFlags
);

    localparam logic [3:0] c_OP_ROL  = 4'd0;
    localparam logic [3:0] c_OP_ROR  = 4'd1;
    localparam logic [3:0] c_OP_MAX  = 4'd2;
    localparam logic [3:0] c_OP_MIN  = 4'd3;
    localparam logic [3:0] c_OP_XNOR = 4'd4;
    localparam logic [3:0] c_OP_ADD  = 4'd5;
    localparam logic [3:0] c_OP_SGT  = 4'd6;
    localparam logic [3:0] c_OP_OR   = 4'd7;
    localparam logic [3:0] c_OP_SUB  = 4'd8;
    localparam logic [3:0] c_OP_AND  = 4'd9;
    localparam logic [3:0] c_OP_XOR  = 4'd10;
    localparam logic [3:0] c_OP_SLT  = 4'd11;

    localparam int         c_MSB     = WIDTH - 1;
    localparam logic [SHW:0] c_WIDTH = WIDTH[SHW:0];

    // ------------------------------------------------------------------
    // Stage 1 registers: captured operands
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [SHW-1:0]   r_s1_sh;

    // ------------------------------------------------------------------
    // Stage 2 registers: result and flags
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;
    logic             r_sign;
    logic             r_illegal;
    logic [3:0]       r_sticky;

    // Handshake: each stage may advance when the stage ahead of it is empty
    // or is being drained this cycle. inReady depends only on state and
    // outReady, never on inValid.
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_out_hs;

    assign w_s2_adv = !r_out_valid || outReady;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_out_hs = r_out_valid && outReady;

    // ------------------------------------------------------------------
    // Combinational ALU on the stage-1 contents
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW:0]     w_rsh;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_ill;
    logic             w_zero;
    logic             w_sign;

    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

    // Rotation as two complementary shifts; an amount of 0 shifts the
    // second term fully out, leaving input1 unchanged.
    assign w_rsh = c_WIDTH - {1'b0, r_s1_sh};
    assign w_rol = (r_s1_a << r_s1_sh) | (r_s1_a >> w_rsh);
    assign w_ror = (r_s1_a >> r_s1_sh) | (r_s1_a << w_rsh);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        case (r_s1_op)
            c_OP_ROL:  w_res = w_rol;
            c_OP_ROR:  w_res = w_ror;
            c_OP_MAX:  w_res = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
            c_OP_MIN:  w_res = (r_s1_a <= r_s1_b) ? r_s1_a : r_s1_b;
            c_OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) &&
                          (w_sum[c_MSB] != r_s1_a[c_MSB]);
            end
            c_OP_SGT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) > $signed(r_s1_b))};
            c_OP_OR:   w_res = r_s1_a | r_s1_b;
            c_OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) &&
                          (w_diff[c_MSB] != r_s1_a[c_MSB]);
            end
            c_OP_AND:  w_res = r_s1_a & r_s1_b;
            c_OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
            default:   w_ill = 1'b1;
        endcase
    end

    assign w_zero = (w_res == '0);
    assign w_sign = w_res[c_MSB];

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sh    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= inValid;
            if (inValid) begin
                r_s1_op <= opcode;
                r_s1_a  <= input1;
                r_s1_b  <= input2;
                r_s1_sh <= shiftValue;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: data only updates on a real beat, so a bubble leaves the
    // previous values in place with outValid low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_res;
                r_carry   <= w_carry;
                r_zero    <= w_zero;
                r_ovf     <= w_ovf;
                r_sign    <= w_sign;
                r_illegal <= w_ill;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a clear coincident with a delivery keeps only that
    // delivered beat's flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (w_out_hs) begin
            r_sticky <= (clearSticky ? 4'b0000 : r_sticky) |
                        {r_carry, r_zero, r_ovf, r_sign};
        end else if (clearSticky) begin
            r_sticky <= '0;
        end
    end

    assign inReady      = w_s1_adv;
    assign outValid     = r_out_valid;
    assign result       = r_result;
    assign carryFlag    = r_carry;
    assign zeroFlag     = r_zero;
    assign overFlowFlag = r_ovf;
    assign signFlag     = r_sign;
    assign illegalOp    = r_illegal;
    assign stickyFlags  = r_sticky;

endmodule
`default_nettype wire
